// File: rtl/sound_pkg.sv
// Shared constants and helpers for the sound channels: widths, duty table,
// frame-sequencer rates and the sweep arithmetic.
package sound_pkg;

    localparam int unsigned FREQ_W = 11;
    localparam int unsigned LEN_W  = 7;
    localparam int unsigned VOL_W  = 4;

    localparam int unsigned TIMER_TICK_HZ = 1048576;
    localparam int unsigned LEN_TICK_HZ   = 256;
    localparam int unsigned SWEEP_TICK_HZ = 128;
    localparam int unsigned ENV_TICK_HZ   = 64;

    typedef enum logic [1:0] {
        Duty12 = 2'd0,
        Duty25 = 2'd1,
        Duty50 = 2'd2,
        Duty75 = 2'd3
    } duty_e;

    // Bit 7 of each pattern is step 0.
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b0111_1110,
        8'b1000_0111,
        8'b1000_0001,
        8'b0000_0001
    };

    function automatic logic duty_bit(duty_e duty, logic [2:0] step);
        return DUTY_TABLE[duty][3'd7 - step];
    endfunction

    // 12-bit result so an add overflow shows up as a value above 2047.
    function automatic logic [FREQ_W:0] sweep_calc(logic [FREQ_W-1:0] freq,
                                                   logic [2:0]        shift,
                                                   logic              decrease);
        logic [FREQ_W:0] base;
        logic [FREQ_W:0] delta;
        base  = {1'b0, freq};
        delta = base >> shift;
        return decrease ? (base - delta) : (base + delta);
    endfunction

endpackage

// File: rtl/sound_ch1_square_if.sv
// Register-field and status bundle for the channel 1 square/sweep generator.
interface sound_ch1_square_if;

    logic                             timer_tick;
    logic                             len_tick;
    logic                             sweep_tick;
    logic                             env_tick;
    logic [2:0]                       sweep_time;
    logic                             sweep_decrease;
    logic [2:0]                       sweep_shift;
    logic [1:0]                       duty;
    logic [5:0]                       length_data;
    logic [sound_pkg::VOL_W-1:0]      init_volume;
    logic                             env_increase;
    logic [2:0]                       env_period;
    logic [sound_pkg::FREQ_W-1:0]     freq;
    logic                             length_enable;
    logic                             trigger;
    logic [sound_pkg::VOL_W-1:0]      sample;
    logic                             ch_on;
    logic [sound_pkg::FREQ_W-1:0]     freq_out;
    logic                             freq_wr;

    modport master (
        output timer_tick, len_tick, sweep_tick, env_tick,
        output sweep_time, sweep_decrease, sweep_shift,
        output duty, length_data,
        output init_volume, env_increase, env_period,
        output freq, length_enable, trigger,
        input  sample, ch_on, freq_out, freq_wr
    );

    modport slave (
        input  timer_tick, len_tick, sweep_tick, env_tick,
        input  sweep_time, sweep_decrease, sweep_shift,
        input  duty, length_data,
        input  init_volume, env_increase, env_period,
        input  freq, length_enable, trigger,
        output sample, ch_on, freq_out, freq_wr
    );

endinterface

// File: rtl/sound_envelope.sv
// Volume envelope shared by the square and noise channels: steps volume by one
// toward the selected direction every env_period envelope ticks.
module sound_envelope
    import sound_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trigger_i,
    input  logic             env_tick_i,
    input  logic [VOL_W-1:0] init_volume_i,
    input  logic             env_increase_i,
    input  logic [2:0]       env_period_i,
    output logic [VOL_W-1:0] volume_o
);

    logic [VOL_W-1:0] volume_q, volume_d;
    logic [2:0]       env_ctr_q, env_ctr_d;

    always_comb begin
        volume_d  = volume_q;
        env_ctr_d = env_ctr_q;
        if (trigger_i) begin
            volume_d  = init_volume_i;
            env_ctr_d = env_period_i;
        end else if (env_tick_i && (env_period_i != 3'd0)) begin
            // A counter of 0 (period raised after a frozen trigger) expires at once.
            if (env_ctr_q <= 3'd1) begin
                env_ctr_d = env_period_i;
                if (env_increase_i && (volume_q != {VOL_W{1'b1}})) begin
                    volume_d = volume_q + 1'b1;
                end else if (!env_increase_i && (volume_q != '0)) begin
                    volume_d = volume_q - 1'b1;
                end
            end else begin
                env_ctr_d = env_ctr_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            volume_q  <= '0;
            env_ctr_q <= '0;
        end else begin
            volume_q  <= volume_d;
            env_ctr_q <= env_ctr_d;
        end
    end

    assign volume_o = volume_q;

endmodule

// File: rtl/sound_ch1_square.sv
// Channel 1: square wave with frequency sweep, length counter and envelope.
// Trigger outranks every tick in the same cycle; reset outranks everything.
module sound_ch1_square
    import sound_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    sound_ch1_square_if.slave        bus
);

    logic [FREQ_W:0]   timer_q, timer_d;
    logic [2:0]        step_q, step_d;
    logic [LEN_W-1:0]  length_ctr_q, length_ctr_d;
    logic [2:0]        sweep_ctr_q, sweep_ctr_d;
    logic              sweep_en_q, sweep_en_d;
    logic [FREQ_W-1:0] shadow_freq_q, shadow_freq_d;
    logic [FREQ_W-1:0] freq_out_q, freq_out_d;
    logic              freq_wr_q, freq_wr_d;
    logic              ch_on_q, ch_on_d;
    logic [VOL_W-1:0]  sample_q, sample_d;
    logic [VOL_W-1:0]  volume;
    logic [FREQ_W:0]   trig_calc;
    logic [FREQ_W:0]   sweep_new;

    sound_envelope u_envelope (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .trigger_i      (bus.trigger),
        .env_tick_i     (bus.env_tick),
        .init_volume_i  (bus.init_volume),
        .env_increase_i (bus.env_increase),
        .env_period_i   (bus.env_period),
        .volume_o       (volume)
    );

    assign trig_calc = sweep_calc(bus.freq, bus.sweep_shift, bus.sweep_decrease);
    assign sweep_new = sweep_calc(shadow_freq_q, bus.sweep_shift, bus.sweep_decrease);

    always_comb begin
        timer_d       = timer_q;
        step_d        = step_q;
        length_ctr_d  = length_ctr_q;
        sweep_ctr_d   = sweep_ctr_q;
        sweep_en_d    = sweep_en_q;
        shadow_freq_d = shadow_freq_q;
        freq_out_d    = freq_out_q;
        freq_wr_d     = 1'b0;
        ch_on_d       = ch_on_q;
        sample_d      = (ch_on_q && duty_bit(duty_e'(bus.duty), step_q)) ? volume : '0;

        if (bus.trigger) begin
            ch_on_d       = 1'b1;
            length_ctr_d  = 7'd64 - {1'b0, bus.length_data};
            timer_d       = 12'd2048 - {1'b0, bus.freq};
            step_d        = 3'd0;
            shadow_freq_d = bus.freq;
            sweep_ctr_d   = bus.sweep_time;
            sweep_en_d    = (bus.sweep_time != 3'd0) || (bus.sweep_shift != 3'd0);
            if ((bus.init_volume == '0) && !bus.env_increase) begin
                ch_on_d = 1'b0;
            end
            if ((bus.sweep_shift != 3'd0) && (trig_calc > 12'd2047)) begin
                ch_on_d = 1'b0;
            end
        end else begin
            if (bus.timer_tick) begin
                if (timer_q <= 12'd1) begin
                    timer_d = 12'd2048 - {1'b0, shadow_freq_q};
                    step_d  = step_q + 3'd1;
                end else begin
                    timer_d = timer_q - 12'd1;
                end
            end

            // With sweep idle the shadow tracks the register; the timer reload above
            // still sees this cycle's old shadow value.
            if (!sweep_en_q) begin
                shadow_freq_d = bus.freq;
            end

            if (bus.len_tick && bus.length_enable && (length_ctr_q != '0)) begin
                length_ctr_d = length_ctr_q - 7'd1;
                if (length_ctr_q == 7'd1) begin
                    ch_on_d = 1'b0;
                end
            end

            if (bus.sweep_tick && sweep_en_q && (bus.sweep_time != 3'd0)) begin
                if (sweep_ctr_q <= 3'd1) begin
                    sweep_ctr_d = bus.sweep_time;
                    if (sweep_new > 12'd2047) begin
                        ch_on_d = 1'b0;
                    end else if (bus.sweep_shift != 3'd0) begin
                        shadow_freq_d = sweep_new[FREQ_W-1:0];
                        freq_out_d    = sweep_new[FREQ_W-1:0];
                        freq_wr_d     = 1'b1;
                    end
                end else begin
                    sweep_ctr_d = sweep_ctr_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q       <= '0;
            step_q        <= '0;
            length_ctr_q  <= '0;
            sweep_ctr_q   <= '0;
            sweep_en_q    <= 1'b0;
            shadow_freq_q <= '0;
            freq_out_q    <= '0;
            freq_wr_q     <= 1'b0;
            ch_on_q       <= 1'b0;
            sample_q      <= '0;
        end else begin
            timer_q       <= timer_d;
            step_q        <= step_d;
            length_ctr_q  <= length_ctr_d;
            sweep_ctr_q   <= sweep_ctr_d;
            sweep_en_q    <= sweep_en_d;
            shadow_freq_q <= shadow_freq_d;
            freq_out_q    <= freq_out_d;
            freq_wr_q     <= freq_wr_d;
            ch_on_q       <= ch_on_d;
            sample_q      <= sample_d;
        end
    end

    assign bus.sample   = sample_q;
    assign bus.ch_on    = ch_on_q;
    assign bus.freq_out = freq_out_q;
    assign bus.freq_wr  = freq_wr_q;

endmodule

// File: tb/tb_sound_ch1_square.sv
// Directed scenarios plus randomized traffic for sound_ch1_square, scored
// against a behavioural channel model.
module tb_sound_ch1_square;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    sound_ch1_square_if bus ();

    sound_ch1_square dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state, plain integers.
    int m_on, m_vol, m_step, m_timer, m_len, m_env, m_swc, m_swen, m_shadow;
    int m_fout, m_fwr, m_sample;
    int duty_tab[4] = '{'h01, 'h81, 'h87, 'h7E};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clock();
        int delta, nv, d, sh, f;
        if (rst) begin
            m_on = 0; m_vol = 0; m_step = 0; m_timer = 0; m_len = 0; m_env = 0;
            m_swc = 0; m_swen = 0; m_shadow = 0; m_fout = 0; m_fwr = 0; m_sample = 0;
            return;
        end
        d  = int'(bus.duty);
        sh = int'(bus.sweep_shift);
        f  = int'(bus.freq);
        m_sample = (m_on != 0 && ((duty_tab[d] >> (7 - m_step)) & 1) != 0) ? m_vol : 0;
        m_fwr = 0;
        if (bus.trigger) begin
            m_on     = 1;
            m_len    = 64 - int'(bus.length_data);
            m_timer  = 2048 - f;
            m_step   = 0;
            m_vol    = int'(bus.init_volume);
            m_env    = int'(bus.env_period);
            m_shadow = f;
            m_swc    = int'(bus.sweep_time);
            m_swen   = (bus.sweep_time != 0 || sh != 0) ? 1 : 0;
            if (bus.init_volume == 0 && !bus.env_increase) m_on = 0;
            if (sh != 0 && !bus.sweep_decrease && f + (f >> sh) > 2047) m_on = 0;
            return;
        end
        if (bus.timer_tick) begin
            if (m_timer <= 1) begin
                m_timer = 2048 - m_shadow;
                m_step  = (m_step + 1) % 8;
            end else begin
                m_timer--;
            end
        end
        if (m_swen == 0) m_shadow = f;
        if (bus.len_tick && bus.length_enable && m_len > 0) begin
            m_len--;
            if (m_len == 0) m_on = 0;
        end
        if (bus.env_tick && bus.env_period != 0) begin
            if (m_env <= 1) begin
                m_env = int'(bus.env_period);
                if (bus.env_increase && m_vol < 15) m_vol++;
                else if (!bus.env_increase && m_vol > 0) m_vol--;
            end else begin
                m_env--;
            end
        end
        if (bus.sweep_tick && m_swen != 0 && bus.sweep_time != 0) begin
            if (m_swc <= 1) begin
                m_swc = int'(bus.sweep_time);
                delta = m_shadow >> sh;
                nv = bus.sweep_decrease ? m_shadow - delta : m_shadow + delta;
                if (nv > 2047) m_on = 0;
                else if (sh != 0) begin
                    m_shadow = nv;
                    m_fout   = nv;
                    m_fwr    = 1;
                end
            end else begin
                m_swc--;
            end
        end
    endtask

    // One clock: model follows the edge, pulses drop at the following negedge.
    task automatic cyc();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        bus.trigger    = 1'b0;
        bus.timer_tick = 1'b0;
        bus.len_tick   = 1'b0;
        bus.sweep_tick = 1'b0;
        bus.env_tick   = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".ch_on"}, int'(bus.ch_on), m_on);
        check_eq({tag, ".sample"}, int'(bus.sample), m_sample);
        check_eq({tag, ".freq_out"}, int'(bus.freq_out), m_fout);
        check_eq({tag, ".freq_wr"}, int'(bus.freq_wr), m_fwr);
    endtask

    task automatic set_defaults();
        bus.sweep_time = 3'd0; bus.sweep_decrease = 1'b0; bus.sweep_shift = 3'd0;
        bus.duty = 2'd2; bus.length_data = 6'd0; bus.init_volume = 4'd15;
        bus.env_increase = 1'b0; bus.env_period = 3'd0; bus.freq = 11'd2047;
        bus.length_enable = 1'b0;
    endtask

    initial begin
        int pat[8] = '{15, 0, 0, 0, 0, 15, 15, 15};
        int vexp[3] = '{1, 0, 0};
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.trigger = 1'b0; bus.timer_tick = 1'b0; bus.len_tick = 1'b0;
        bus.sweep_tick = 1'b0; bus.env_tick = 1'b0;
        set_defaults();
        @(negedge clk);
        cyc();
        cyc();
        check_eq("reset.ch_on", int'(bus.ch_on), 0);
        check_eq("reset.sample", int'(bus.sample), 0);
        check_eq("reset.freq_out", int'(bus.freq_out), 0);
        check_eq("reset.freq_wr", int'(bus.freq_wr), 0);
        rst = 1'b0;

        // Duty 50% pattern at the fastest frequency.
        bus.trigger = 1'b1;
        cyc();
        for (int k = 0; k < 16; k++) begin
            bus.timer_tick = 1'b1;
            cyc();
            check_eq($sformatf("duty.step%0d", k % 8), int'(bus.sample), pat[k % 8]);
            check_model("duty");
        end

        // Length expiry, then the same with length disabled.
        for (int le = 1; le >= 0; le--) begin
            set_defaults();
            bus.length_data = 6'd62;
            bus.length_enable = le[0];
            bus.trigger = 1'b1;
            cyc();
            bus.len_tick = 1'b1;
            cyc();
            check_eq($sformatf("len%0d.tick1", le), int'(bus.ch_on), 1);
            bus.len_tick = 1'b1;
            cyc();
            check_eq($sformatf("len%0d.tick2", le), int'(bus.ch_on), le == 1 ? 0 : 1);
            check_model("len");
        end

        // Envelope decay to zero keeps the channel on.
        set_defaults();
        bus.init_volume = 4'd2; bus.env_period = 3'd1;
        bus.trigger = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            bus.env_tick = 1'b1;
            cyc();
            cyc();
            check_eq($sformatf("env.vol%0d", k), int'(bus.sample), vexp[k]);
            check_eq($sformatf("env.on%0d", k), int'(bus.ch_on), 1);
        end

        // Sweep write-back then overflow.
        set_defaults();
        bus.freq = 11'd1024; bus.sweep_time = 3'd1; bus.sweep_shift = 3'd1;
        bus.trigger = 1'b1;
        cyc();
        bus.sweep_tick = 1'b1;
        cyc();
        check_eq("sweep1.freq_out", int'(bus.freq_out), 1536);
        check_eq("sweep1.freq_wr", int'(bus.freq_wr), 1);
        cyc();
        check_eq("sweep1.wr_drop", int'(bus.freq_wr), 0);
        bus.sweep_tick = 1'b1;
        cyc();
        check_eq("sweep2.ch_on", int'(bus.ch_on), 0);
        check_eq("sweep2.freq_wr", int'(bus.freq_wr), 0);
        check_eq("sweep2.freq_out", int'(bus.freq_out), 1536);
        check_model("sweep");

        // DAC off at trigger.
        set_defaults();
        bus.init_volume = 4'd0;
        bus.trigger = 1'b1;
        cyc();
        cyc();
        check_eq("dacoff.ch_on", int'(bus.ch_on), 0);
        check_eq("dacoff.sample", int'(bus.sample), 0);

        // Trigger swallows coincident length and envelope ticks.
        set_defaults();
        bus.init_volume = 4'd5; bus.env_period = 3'd1;
        bus.length_data = 6'd62; bus.length_enable = 1'b1;
        bus.trigger = 1'b1; bus.len_tick = 1'b1; bus.env_tick = 1'b1;
        cyc();
        cyc();
        check_eq("coinc.volume", int'(bus.sample), 5);
        bus.len_tick = 1'b1;
        cyc();
        check_eq("coinc.len1", int'(bus.ch_on), 1);
        bus.len_tick = 1'b1;
        cyc();
        check_eq("coinc.len2", int'(bus.ch_on), 0);

        // Reset beats a same-cycle trigger and ticks.
        set_defaults();
        bus.trigger = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        bus.trigger = 1'b1; bus.timer_tick = 1'b1; bus.len_tick = 1'b1;
        bus.sweep_tick = 1'b1; bus.env_tick = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("rsttrig.ch_on", int'(bus.ch_on), 0);
        check_eq("rsttrig.sample", int'(bus.sample), 0);
        check_eq("rsttrig.freq_out", int'(bus.freq_out), 0);
        check_eq("rsttrig.freq_wr", int'(bus.freq_wr), 0);
        check_model("rsttrig");

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 31) == 0) begin
                bus.duty = 2'($urandom_range(0, 3));
                bus.sweep_time = 3'($urandom_range(0, 7));
                bus.sweep_decrease = 1'($urandom_range(0, 1));
                bus.sweep_shift = 3'($urandom_range(0, 7));
                bus.length_data = 6'($urandom_range(40, 63));
                bus.init_volume = 4'($urandom_range(0, 15));
                bus.env_increase = 1'($urandom_range(0, 1));
                bus.env_period = 3'($urandom_range(0, 7));
                bus.length_enable = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 15) == 0) begin
                bus.freq = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                       : 11'($urandom_range(1900, 2047));
            end
            bus.trigger    = ($urandom_range(0, 39) == 0);
            bus.timer_tick = ($urandom_range(0, 1) == 0);
            bus.len_tick   = ($urandom_range(0, 5) == 0);
            bus.sweep_tick = ($urandom_range(0, 5) == 0);
            bus.env_tick   = ($urandom_range(0, 5) == 0);
            rst            = ($urandom_range(0, 699) == 0);
            cyc();
            rst = 1'b0;
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
